nanov_spi_arbiter: RTL and testbench

Transaction-level arbiter and sequencer for the single external SPI memory on the nanoV board. Two requesters (port 0 and port 1, e.g. CPU memory port and loader/debug port) each issue 32-bit word reads or writes. The block grants one at a time by round robin, then drives the complete SPI transaction bit-serially: command, 24-bit address, 32 data bits. Its select/data/clock-enable outputs feed the top-level pin registers, and `spi_clk_out = !clk && spi_clk_enable` is generated outside the block.

---
 rtl/nanov_spi_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_nanov_spi_arbiter.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nanov_spi_arbiter.sv
// Round-robin arbiter for two word requesters sharing the nanoV SPI memory;
// each grant is sequenced bit-serially as command, 24-bit address, 32 data bits.
module nanov_spi_arbiter #(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned SELECT_GAP   = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [23:0] addr0,
  input  logic [23:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata,
  input  logic        spi_miso,
  output logic        spi_select,
  output logic        spi_mosi,
  output logic        spi_clk_enable
);

  localparam int unsigned CNT_W   = 7;
  localparam int unsigned GAP_W   = 3;
  localparam int unsigned ADDR_W  = 24;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHIFT_W = 8 + ADDR_W + DATA_W;

  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(7);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(31);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(63);
  localparam logic [CNT_W-1:0] TAIL_LAST = CNT_W'(63 + READ_LATENCY);
  localparam logic [CNT_W-1:0] CAP_FIRST = CNT_W'(32 + READ_LATENCY);
  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'((SELECT_GAP > 1) ? (SELECT_GAP - 2) : 0);
  localparam logic [7:0]       CMD_WRITE = 8'h02;
  localparam logic [7:0]       CMD_READ  = 8'h03;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, TAIL, DONE, GAP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SHIFT_W-1:0]  shift_q, shift_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                we_q, we_d;
  logic                port_q, port_d;
  logic                last_q, last_d;
  logic                select_q, select_d;
  logic                mosi_q, mosi_d;
  logic                clk_en_q, clk_en_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;

  // Port 1 wins when alone, or when both request and port 0 had the last grant.
  logic                grant1;
  logic                g_we;
  logic [ADDR_W-1:0]   g_addr;
  logic [DATA_W-1:0]   g_wdata;
  logic [SHIFT_W-1:0]  load_word;
  logic                capture;
  logic                finish;

  assign grant1    = req1 & (~req0 | ~last_q);
  assign g_we      = grant1 ? we1 : we0;
  assign g_addr    = grant1 ? addr1 : addr0;
  assign g_wdata   = grant1 ? wdata1 : wdata0;
  assign load_word = {(g_we ? CMD_WRITE : CMD_READ), g_addr, (g_we ? g_wdata : DATA_W'(0))};
  assign capture   = ~we_q & ((state_q == DATA) | (state_q == TAIL)) & (cnt_q >= CAP_FIRST);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    gap_d    = gap_q;
    rdata_d  = rdata_q;
    we_d     = we_q;
    port_d   = port_q;
    last_d   = last_q;
    select_d = select_q;
    mosi_d   = mosi_q;
    clk_en_d = clk_en_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    finish   = 1'b0;

    if (capture) rdata_d = {rdata_q[DATA_W-2:0], spi_miso};

    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d  = CMD;
          cnt_d    = '0;
          shift_d  = load_word;
          we_d     = g_we;
          port_d   = grant1;
          last_d   = grant1;
          select_d = 1'b0;
          clk_en_d = 1'b1;
          mosi_d   = load_word[SHIFT_W-1];
        end
      end
      CMD, ADDR, DATA: begin
        cnt_d   = cnt_q + CNT_W'(1);
        shift_d = {shift_q[SHIFT_W-2:0], 1'b0};
        mosi_d  = shift_q[SHIFT_W-2];
        if (state_q == CMD && cnt_q == CMD_LAST) state_d = ADDR;
        if (state_q == ADDR && cnt_q == ADDR_LAST) state_d = DATA;
        if (state_q == DATA && cnt_q == DATA_LAST) begin
          if (!we_q && READ_LATENCY != 0) begin
            state_d  = TAIL;
            clk_en_d = 1'b0;
            mosi_d   = 1'b0;
          end else begin
            finish = 1'b1;
          end
        end
      end
      // Select stays low while the last read bits drain back through the pad buffer.
      TAIL: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == TAIL_LAST) finish = 1'b1;
      end
      DONE: begin
        if (SELECT_GAP > 1) begin
          state_d = GAP;
          gap_d   = GAP_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else gap_d = gap_q - GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase

    if (finish) begin
      state_d  = DONE;
      select_d = 1'b1;
      clk_en_d = 1'b0;
      mosi_d   = 1'b0;
      ack0_d   = ~port_q;
      ack1_d   = port_q;
    end
  end

  // Reset points the round-robin at port 1 so port 0 wins the first contest.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      gap_q    <= '0;
      rdata_q  <= '0;
      we_q     <= 1'b0;
      port_q   <= 1'b0;
      last_q   <= 1'b1;
      select_q <= 1'b1;
      mosi_q   <= 1'b0;
      clk_en_q <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      gap_q    <= gap_d;
      rdata_q  <= rdata_d;
      we_q     <= we_d;
      port_q   <= port_d;
      last_q   <= last_d;
      select_q <= select_d;
      mosi_q   <= mosi_d;
      clk_en_q <= clk_en_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
    end
  end

  assign ack0           = ack0_q;
  assign ack1           = ack1_q;
  assign rdata          = rdata_q;
  assign spi_select     = select_q;
  assign spi_mosi       = mosi_q;
  assign spi_clk_enable = clk_en_q;

endmodule

// File: tb/tb_nanov_spi_arbiter.sv
// Bench for nanov_spi_arbiter: three instances (READ_LATENCY/SELECT_GAP = 1/1, 0/1, 1/3)
// with an SPI memory model per instance and a transaction scoreboard.
module tb_nanov_spi_arbiter;

  localparam int NI   = 3;
  localparam int RL_A = 1;
  localparam int RL_B = 0;
  localparam int SG_A = 1;
  localparam int SG_C = 3;

  typedef struct {
    int          inst;
    bit          port;
    logic [63:0] tx;
    int          low;
    int          en;
    bit          both;
    logic [31:0] rd;
  } rec_t;

  typedef struct {
    int inst;
    int run;
  } gap_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req0 [NI];
  logic        req1 [NI];
  logic        we0 [NI];
  logic        we1 [NI];
  logic [23:0] addr0 [NI];
  logic [23:0] addr1 [NI];
  logic [31:0] wdata0 [NI];
  logic [31:0] wdata1 [NI];
  logic        ack0 [NI];
  logic        ack1 [NI];
  logic [31:0] rdata [NI];
  logic        miso [NI];
  logic        sel [NI];
  logic        mosi [NI];
  logic        en [NI];

  logic [31:0] slave_data [NI];
  logic [31:0] last_rd [NI];
  logic [3:0]  hist [NI];
  logic [63:0] tx [NI];
  int          low_cnt [NI];
  int          en_cnt [NI];
  int          hi_run [NI];
  bit          seen [NI];
  logic        sel_prev [NI];
  int          en_high [NI] = '{default: 0};

  rec_t exp_q[$];
  rec_t act_q[$];
  gap_t gap_q[$];

  int tests_run = 0;
  int failed    = 0;

  always #5 clk = ~clk;

  nanov_spi_arbiter #(.READ_LATENCY(RL_A), .SELECT_GAP(SG_A)) dut_a (
    .clk(clk), .rstn(rstn), .req0(req0[0]), .req1(req1[0]), .we0(we0[0]), .we1(we1[0]),
    .addr0(addr0[0]), .addr1(addr1[0]), .wdata0(wdata0[0]), .wdata1(wdata1[0]),
    .ack0(ack0[0]), .ack1(ack1[0]), .rdata(rdata[0]), .spi_miso(miso[0]),
    .spi_select(sel[0]), .spi_mosi(mosi[0]), .spi_clk_enable(en[0]));

  nanov_spi_arbiter #(.READ_LATENCY(RL_B), .SELECT_GAP(SG_A)) dut_b (
    .clk(clk), .rstn(rstn), .req0(req0[1]), .req1(req1[1]), .we0(we0[1]), .we1(we1[1]),
    .addr0(addr0[1]), .addr1(addr1[1]), .wdata0(wdata0[1]), .wdata1(wdata1[1]),
    .ack0(ack0[1]), .ack1(ack1[1]), .rdata(rdata[1]), .spi_miso(miso[1]),
    .spi_select(sel[1]), .spi_mosi(mosi[1]), .spi_clk_enable(en[1]));

  nanov_spi_arbiter #(.READ_LATENCY(RL_A), .SELECT_GAP(SG_C)) dut_c (
    .clk(clk), .rstn(rstn), .req0(req0[2]), .req1(req1[2]), .we0(we0[2]), .we1(we1[2]),
    .addr0(addr0[2]), .addr1(addr1[2]), .wdata0(wdata0[2]), .wdata1(wdata1[2]),
    .ack0(ack0[2]), .ack1(ack1[2]), .rdata(rdata[2]), .spi_miso(miso[2]),
    .spi_select(sel[2]), .spi_mosi(mosi[2]), .spi_clk_enable(en[2]));

  function automatic int rl_of(input int i);
    return (i == 1) ? RL_B : RL_A;
  endfunction

  // SPI memory model and bus monitor; the data bit clocked in enabled cycle k
  // reaches miso READ_LATENCY cycles later.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      logic cur;
      rec_t r;
      gap_t g;
      cur = 1'b0;
      if (!rstn) begin
        hist[i]     = '0;
        miso[i]     = 1'b0;
        tx[i]       = '0;
        low_cnt[i]  = 0;
        en_cnt[i]   = 0;
        hi_run[i]   = 0;
        seen[i]     = 1'b0;
        sel_prev[i] = 1'b1;
      end else begin
        if (sel[i] === 1'b0) begin
          if (sel_prev[i] === 1'b1) begin
            if (seen[i]) begin
              g.inst = i;
              g.run  = hi_run[i];
              gap_q.push_back(g);
            end
            tx[i]      = '0;
            low_cnt[i] = 0;
            en_cnt[i]  = 0;
          end
          low_cnt[i]++;
          if (en[i] === 1'b1) begin
            if (en_cnt[i] >= 32 && en_cnt[i] < 64) cur = slave_data[i][5'(63 - en_cnt[i])];
            tx[i] = {tx[i][62:0], mosi[i]};
            en_cnt[i]++;
          end
          hi_run[i] = 0;
        end else begin
          hi_run[i]++;
          if (en[i] !== 1'b0) en_high[i]++;
        end
        hist[i] = {hist[i][2:0], cur};
        miso[i] = hist[i][rl_of(i)];
        if (ack0[i] === 1'b1 || ack1[i] === 1'b1) begin
          r.inst = i;
          r.port = (ack1[i] === 1'b1);
          r.tx   = tx[i];
          r.low  = low_cnt[i];
          r.en   = en_cnt[i];
          r.both = (ack0[i] === 1'b1) && (ack1[i] === 1'b1);
          r.rd   = rdata[i];
          act_q.push_back(r);
          seen[i] = 1'b1;
        end
        sel_prev[i] = sel[i];
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic exp_push(input int i, input bit port, input bit w, input logic [23:0] a,
                          input logic [31:0] d, input logic [31:0] rd);
    rec_t e;
    e.inst = i;
    e.port = port;
    e.tx   = {(w ? 8'h02 : 8'h03), a, (w ? d : 32'h0)};
    e.low  = 64 + (w ? 0 : rl_of(i));
    e.en   = 64;
    e.both = 1'b0;
    if (!w) last_rd[i] = rd;
    e.rd   = last_rd[i];
    exp_q.push_back(e);
  endtask

  task automatic drive(input int i, input bit port, input bit w, input logic [23:0] a,
                       input logic [31:0] d);
    if (port) begin
      req1[i] = 1'b1; we1[i] = w; addr1[i] = a; wdata1[i] = d;
    end else begin
      req0[i] = 1'b1; we0[i] = w; addr0[i] = a; wdata0[i] = d;
    end
  endtask

  task automatic start_req(input int i, input bit port, input bit w, input logic [23:0] a,
                           input logic [31:0] d, input logic [31:0] rd);
    slave_data[i] = rd;
    exp_push(i, port, w, a, d, rd);
    drive(i, port, w, a, d);
  endtask

  // Waits for the ack, releases the request in the ack cycle, optionally checks latency.
  task automatic wait_ack(input int i, input int expect_cycles);
    int  k;
    bit  got;
    k   = 0;
    got = 1'b0;
    while (!got && k < 400) begin
      tick();
      k++;
      if (ack0[i] === 1'b1 || ack1[i] === 1'b1) got = 1'b1;
    end
    req0[i] = 1'b0;
    req1[i] = 1'b0;
    tests_run++;
    if (!got || (expect_cycles >= 0 && k != expect_cycles)) begin
      failed++;
      $display("FAIL ack_latency inst%0d: ack seen=%0b after %0d cycles, expected %0d", i, got, k, expect_cycles);
    end
  endtask

  task automatic wait_records(input int n);
    int k;
    k = 0;
    while (act_q.size() < n && k < 800) begin
      tick();
      k++;
    end
  endtask

  // Scoreboard: pop DUT completions in order and compare against expected transactions.
  task automatic sb_compare(input int n);
    rec_t a;
    rec_t e;
    for (int m = 0; m < n; m++) begin
      wait_records(1);
      if (act_q.size() == 0 || exp_q.size() == 0) begin
        tests_run++;
        failed++;
        $display("FAIL sb_missing: completions=%0d expected entries=%0d", act_q.size(), exp_q.size());
        return;
      end
      a = act_q.pop_front();
      e = exp_q.pop_front();
      tests_run++;
      if (a.inst != e.inst || a.port !== e.port || a.both) begin
        failed++;
        $display("FAIL grant: inst%0d port=%0b both_acks=%0b, expected inst%0d port=%0b", a.inst, a.port, a.both, e.inst, e.port);
      end
      tests_run++;
      if (a.tx !== e.tx) begin
        failed++;
        $display("FAIL mosi_stream inst%0d: got %h expected %h", a.inst, a.tx, e.tx);
      end
      tests_run++;
      if (a.low != e.low || a.en != e.en) begin
        failed++;
        $display("FAIL select_window inst%0d: select low %0d en %0d, expected low %0d en %0d", a.inst, a.low, a.en, e.low, e.en);
      end
      tests_run++;
      if (a.rd !== e.rd) begin
        failed++;
        $display("FAIL rdata inst%0d: got %h expected %h", a.inst, a.rd, e.rd);
      end
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    for (int i = 0; i < NI; i++) begin
      req0[i] = 1'b0;
      req1[i] = 1'b0;
      last_rd[i] = 32'h0;
    end
    tick();
    tick();
    exp_q.delete();
    act_q.delete();
    gap_q.delete();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    for (int i = 0; i < NI; i++) begin
      req0[i] = 1'b1; req1[i] = 1'b0; we0[i] = 1'b1; we1[i] = 1'b0;
      addr0[i] = 24'h0; addr1[i] = 24'h0; wdata0[i] = 32'h0; wdata1[i] = 32'h0;
      slave_data[i] = 32'h0; last_rd[i] = 32'h0;
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int i = 0; i < NI; i++) begin
        tests_run++;
        if ({sel[i], mosi[i], en[i], ack0[i], ack1[i]} !== 5'b10000 || rdata[i] !== 32'h0) begin
          failed++;
          $display("FAIL reset_hold inst%0d cycle%0d: sel=%b mosi=%b en=%b ack0=%b ack1=%b rdata=%h, expected 1 0 0 0 0 0",
                   i, c, sel[i], mosi[i], en[i], ack0[i], ack1[i], rdata[i]);
        end
      end
    end
    for (int i = 0; i < NI; i++) req0[i] = 1'b0;
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_write();
    do_reset();
    start_req(0, 1'b0, 1'b1, 24'h001234, 32'hDEADBEEF, 32'h0);
    wait_ack(0, 65);
    sb_compare(1);
    tick(); tick(); tick();
    tests_run++;
    if (act_q.size() != 0) begin
      failed++;
      $display("FAIL extra_ack: %0d unexpected completions, expected 0", act_q.size());
    end
  endtask

  task automatic test_read_latency();
    start_req(0, 1'b1, 1'b0, 24'hABCDEF, 32'h0, 32'hCAFEF00D);
    wait_ack(0, 65 + RL_A);
    sb_compare(1);
    start_req(1, 1'b1, 1'b0, 24'hABCDEF, 32'h0, 32'hCAFEF00D);
    wait_ack(1, 65 + RL_B);
    sb_compare(1);
    tick();
    start_req(0, 1'b0, 1'b1, 24'h00FF00, 32'h01234567, 32'h0);
    wait_ack(0, 65);
    sb_compare(1);
  endtask

  task automatic test_input_change();
    int k;
    tick();
    start_req(0, 1'b0, 1'b1, 24'h00A5A5, 32'h12345678, 32'h0);
    k = 0;
    while (sel[0] !== 1'b0 && k < 10) begin
      tick();
      k++;
    end
    tests_run++;
    if (sel[0] !== 1'b0) begin
      failed++;
      $display("FAIL grant_timeout: select=%b, expected 0", sel[0]);
    end
    addr0[0]  = 24'hFFFFFF;
    wdata0[0] = 32'h00000000;
    we0[0]    = 1'b0;
    wait_ack(0, -1);
    sb_compare(1);
  endtask

  task automatic test_reset_mid();
    int k;
    tick();
    drive(0, 1'b0, 1'b1, 24'h123456, 32'hFFFFFFFF);
    k = 0;
    while (en_cnt[0] < 20 && k < 40) begin
      tick();
      k++;
    end
    rstn = 1'b0;
    #1;
    tests_run++;
    if ({sel[0], en[0], mosi[0], ack0[0], ack1[0]} !== 5'b10000 || rdata[0] !== 32'h0) begin
      failed++;
      $display("FAIL reset_mid: sel=%b en=%b mosi=%b ack0=%b ack1=%b rdata=%h, expected 1 0 0 0 0 0",
               sel[0], en[0], mosi[0], ack0[0], ack1[0], rdata[0]);
    end
    do_reset();
    start_req(0, 1'b1, 1'b1, 24'h0000FF, 32'hA5A55A5A, 32'h0);
    wait_ack(0, 65);
    sb_compare(1);
  endtask

  task automatic check_gaps(input int n, input int want);
    gap_t g;
    tests_run++;
    if (gap_q.size() != n) begin
      failed++;
      $display("FAIL gap_count: got %0d gaps, expected %0d", gap_q.size(), n);
    end
    while (gap_q.size() > 0) begin
      g = gap_q.pop_front();
      tests_run++;
      if (g.run != want) begin
        failed++;
        $display("FAIL select_gap inst%0d: %0d select-high cycles, expected %0d", g.inst, g.run, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    slave_data[0] = 32'h55AA33CC;
    exp_push(0, 1'b0, 1'b1, 24'h000100, 32'h11111111, 32'h0);
    exp_push(0, 1'b1, 1'b0, 24'h000200, 32'h0, 32'h55AA33CC);
    exp_push(0, 1'b0, 1'b1, 24'h000100, 32'h11111111, 32'h0);
    exp_push(0, 1'b1, 1'b0, 24'h000200, 32'h0, 32'h55AA33CC);
    drive(0, 1'b0, 1'b1, 24'h000100, 32'h11111111);
    drive(0, 1'b1, 1'b0, 24'h000200, 32'h0);
    wait_records(4);
    req0[0] = 1'b0;
    req1[0] = 1'b0;
    sb_compare(4);
    check_gaps(3, SG_A + 1);
  endtask

  task automatic test_select_gap();
    do_reset();
    slave_data[2] = 32'h0F0F1234;
    for (int m = 0; m < 3; m++) exp_push(2, 1'b0, 1'b0, 24'h000040, 32'h0, 32'h0F0F1234);
    drive(2, 1'b0, 1'b0, 24'h000040, 32'h0);
    wait_records(3);
    req0[2] = 1'b0;
    sb_compare(3);
    check_gaps(2, SG_C + 1);
    tick(); tick(); tick();
    tests_run++;
    if (act_q.size() != 0) begin
      failed++;
      $display("FAIL extra_ack_gap: %0d unexpected completions, expected 0", act_q.size());
    end
    for (int i = 0; i < NI; i++) begin
      tests_run++;
      if (en_high[i] != 0) begin
        failed++;
        $display("FAIL clk_enable_while_deselected inst%0d: %0d cycles, expected 0", i, en_high[i]);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read_latency();
    test_input_change();
    test_reset_mid();
    test_back_to_back();
    test_select_gap();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
